// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron MAC datapath and its controller.
package nn_pkg;

  // Controller phases: collecting products, or holding a finished result.
  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } nn_state_e;

  // Accumulator width that holds num_weight worst-case signed products
  // without overflow (one extra bit covers the -2^(2w-2) * 2 corner).
  function automatic int acc_width(input int num_weight, input int data_width);
    return 2 * data_width + $clog2(num_weight) + 1;
  endfunction

endpackage

// File: rtl/neuron_mac_ctrl_if.sv
// Bundle of the input stream, weight-memory read port and result stream.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// exactly when valid and ready are both high in the cycle before that edge.
// A source holds valid and its payload until the transfer; a sink may raise
// or drop ready at any time.
interface neuron_mac_ctrl_if
  import nn_pkg::*;
#(
  parameter int NUM_WEIGHT = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  localparam int ACC_WIDTH = acc_width(NUM_WEIGHT, DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic [ADDR_WIDTH-1:0] out_last_idx;
  nn_state_e             state_dbg;

  // Upstream producer, weight memory and downstream consumer side.
  modport master (
    output in_valid, in_data, w_data, out_ready,
    input  in_ready, w_addr, out_valid, out_data, out_last_idx, state_dbg
  );

  // The controller side.
  modport slave (
    input  in_valid, in_data, w_data, out_ready,
    output in_ready, w_addr, out_valid, out_data, out_last_idx, state_dbg
  );

endinterface

// File: rtl/nn_mac.sv
// Signed multiply-accumulate: full-precision product of two DATA_WIDTH
// operands, sign-extended and added into an ACC_WIDTH accumulator.
module nn_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 35
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic        [ACC_WIDTH-1:0]  sum
);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  logic signed [PROD_WIDTH-1:0] prod;
  logic        [ACC_WIDTH-1:0]  acc;

  assign prod = a * b;
  // sum is the value acc would take if this cycle's product were accepted.
  assign sum  = acc + {{(ACC_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

  // Accumulator register: clear wins over accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/neuron_mac_ctrl.sv
// Sequencer for one neuron: walks the weight address in step with the input
// stream, accumulates input*weight, and offers the dot product downstream.
module neuron_mac_ctrl
  import nn_pkg::*;
#(
  parameter int NUM_WEIGHT = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  neuron_mac_ctrl_if.slave bus
);
  localparam int ACC_WIDTH = acc_width(NUM_WEIGHT, DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WEIGHT - 1);

  nn_state_e             state;
  logic [ADDR_WIDTH-1:0] count;
  logic [ACC_WIDTH-1:0]  mac_sum;
  logic                  beat_ok;
  logic                  result_hs;

  // clear overrides both the input beat and the result handshake.
  assign beat_ok   = (state == ACCUM) && bus.in_valid && bus.in_ready && !clear;
  assign result_hs = (state == OUTPUT) && bus.out_ready && !clear;

  // The weight address is the registered beat counter itself.
  assign bus.w_addr    = count;
  assign bus.state_dbg = state;

  nn_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear || result_hs),
    .en    (beat_ok),
    .a     (bus.in_data),
    .b     (bus.w_data),
    .sum   (mac_sum)
  );

  // Controller FSM with registered handshake outputs, counter and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ACCUM;
      count            <= '0;
      bus.in_ready     <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.out_data     <= '0;
      bus.out_last_idx <= '0;
    end else if (clear) begin
      state         <= ACCUM;
      count         <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (beat_ok) begin
            if (count == LAST_IDX) begin
              bus.out_data     <= mac_sum;
              bus.out_last_idx <= LAST_IDX;
              count            <= '0;
              bus.in_ready     <= 1'b0;
              bus.out_valid    <= 1'b1;
              state            <= OUTPUT;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (result_hs) begin
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            state         <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

  // The beat counter never runs past the last weight.
  a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
    int'(count) < NUM_WEIGHT);

  // A result held under backpressure does not change.
  a_out_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> $stable(bus.out_data));

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Bench for neuron_mac_ctrl: directed vectors from the test plan followed by
// randomized vectors, checked by a dot-product reference model and scoreboard.
module tb_neuron_mac_ctrl;
  import nn_pkg::*;

  localparam int NW    = 3;
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int ACC_W = acc_width(NW, DW);

  logic clk;
  logic rst_n;
  logic clear;

  neuron_mac_ctrl_if #(.NUM_WEIGHT(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  neuron_mac_ctrl #(.NUM_WEIGHT(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  // Combinational-read weight memory.
  logic [DW-1:0] wmem [0:(1<<AW)-1];
  assign bus.w_data = wmem[bus.w_addr];

  // Scoreboard and reference-model state.
  logic [ACC_W-1:0] exp_q[$];
  longint           cur_in[$];
  longint           cur_w[$];
  int               checks;
  int               errors;
  bit               lat_pending;
  bit               ready_after_hs;
  bit               rand_ready;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset empties the model: partial sums and pending results are gone.
  initial forever begin
    @(negedge rst_n);
    cur_in.delete();
    cur_w.delete();
    exp_q.delete();
    lat_pending    = 0;
    ready_after_hs = 0;
  end

  // ---------------- reference model ----------------
  // Tracks accepted beats; a full vector yields sum(in[i]*w[i]).
  initial forever begin
    @(negedge clk);
    if (!rst_n) continue;
    if (lat_pending) begin
      chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
      lat_pending = 0;
    end
    if (clear) begin
      cur_in.delete();
      cur_w.delete();
      exp_q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      longint s;
      chk("w_addr_seq", 64'(bus.w_addr), 64'(cur_in.size()));
      cur_w.push_back(longint'($signed(wmem[cur_in.size()])));
      cur_in.push_back(longint'($signed(bus.in_data)));
      if (cur_in.size() == NW) begin
        s = 0;
        for (int i = 0; i < NW; i++) s += cur_in[i] * cur_w[i];
        exp_q.push_back(ACC_W'(s));
        cur_in.delete();
        cur_w.delete();
        lat_pending = 1;
      end
    end
  end

  // ---------------- output monitor ----------------
  initial forever begin
    @(negedge clk);
    if (!rst_n || clear) continue;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got out_valid=1 data 0x%0h expected no result at %0t",
                 bus.out_data, $time);
      end else begin
        chk("in_ready_in_output", 64'(bus.in_ready), 64'd0);
        if (bus.out_ready) begin
          logic [ACC_W-1:0] e;
          e = exp_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e));
          chk("out_last_idx", 64'(bus.out_last_idx), 64'(NW - 1));
          ready_after_hs = 1;
        end else begin
          chk("out_data_hold", 64'(bus.out_data), 64'(exp_q[0]));
        end
      end
    end else if (ready_after_hs) begin
      chk("in_ready_after_hs", 64'(bus.in_ready), 64'd1);
      ready_after_hs = 0;
    end
  end

  // Random downstream backpressure, updated away from the main driver's slot.
  initial forever begin
    @(posedge clk);
    #2;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic set_weights(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2);
    wmem[0] = w0;
    wmem[1] = w1;
    wmem[2] = w2;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input int gap);
    int n;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = DW'($urandom_range(0, 65535));
  endtask

  task automatic send_vec(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c);
    send_beat(a, 0);
    send_beat(b, 0);
    send_beat(c, 0);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      tick();
      n++;
    end
    chk("idle_reached", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
    chk({tag, "_w_addr"}, 64'(bus.w_addr), 64'd0);
    chk({tag, "_out_last_idx"}, 64'(bus.out_last_idx), 64'd0);
  endtask

  // Drops reset between clock edges, checks outputs before any edge, then releases.
  task automatic async_reset(input string tag);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks       = 0;
    errors       = 0;
    rand_ready   = 0;
    rst_n        = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < (1 << AW); i++) wmem[i] = '0;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    tick();
    #2;
    rst_n = 1'b1;
    tick();

    // Basic dot product: 4*1 + 5*2 + 6*3 = 32.
    bus.out_ready = 1'b1;
    set_weights(16'h0001, 16'h0002, 16'h0003);
    send_vec(16'd4, 16'd5, 16'd6);
    wait_idle();

    // Signed extremes: 32768 - 1073709056 + 1073741824 = 65536.
    set_weights(16'hFFFF, 16'h7FFF, 16'h8000);
    send_vec(16'h8000, 16'h8000, 16'h8000);
    wait_idle();

    // Backpressure: hold the result for 5 cycles, then a second vector.
    set_weights(16'h0001, 16'h0002, 16'h0003);
    bus.out_ready = 1'b0;
    send_vec(16'd7, 16'hFFFF, 16'd2);
    wait_out_valid();
    repeat (5) tick();
    bus.out_ready = 1'b1;
    wait_idle();
    send_vec(16'd10, 16'd20, 16'd30);
    wait_idle();

    // Gapped input: valid pattern 1,0,0,1,0,1.
    send_beat(16'd4, 0);
    send_beat(16'd5, 2);
    send_beat(16'd6, 1);
    wait_idle();

    // Clear after two beats with a beat presented in the clear cycle.
    send_beat(16'd4, 0);
    send_beat(16'd5, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd9;
    clear        = 1'b1;
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    send_vec(16'd1, 16'd1, 16'd1);
    wait_idle();

    // Clear while a result is pending: it must be discarded.
    bus.out_ready = 1'b0;
    send_vec(16'd2, 16'd2, 16'd2);
    wait_out_valid();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    send_vec(16'd3, 16'd3, 16'd3);
    wait_idle();

    // Reset mid-vector, then a clean vector.
    send_beat(16'd4, 0);
    async_reset("rst_mid");
    send_vec(16'd4, 16'd5, 16'd6);
    wait_idle();

    // Reset while holding a result, then a clean vector.
    bus.out_ready = 1'b0;
    send_vec(16'd1, 16'd2, 16'd3);
    wait_out_valid();
    async_reset("rst_output");
    bus.out_ready = 1'b1;
    send_vec(16'd4, 16'd5, 16'd6);
    wait_idle();

    // Randomized vectors with random gaps, weights and backpressure.
    rand_ready = 1;
    for (int v = 0; v < 30; v++) begin
      logic [DW-1:0] d;
      for (int i = 0; i < NW; i++) begin
        wmem[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : DW'($urandom_range(0, 65535));
      end
      for (int i = 0; i < NW; i++) begin
        d = ($urandom_range(0, 7) == 0) ? 16'h8000 : DW'($urandom_range(0, 65535));
        send_beat(d, $urandom_range(0, 3));
      end
    end
    rand_ready = 0;
    tick();
    bus.out_ready = 1'b1;
    wait_idle();
    chk("drain_cur_vec", 64'(cur_in.size()), 64'd0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
